// File: rtl/aes_subbytes_seq.sv
`timescale 1ns/1ps
// aes_subbytes_seq: sequential forward AES SubBytes engine.
// Takes a 128-bit state over a valid/ready handshake and substitutes
// WORDS_PER_CYCLE 32-bit words per step through the FIPS-197 forward S-box.
// It returns the result over a second valid/ready handshake.
// Optional macro SUBBYTES_PIPE_EN adds a register stage between the S-box
// lanes and the block register, so each step becomes lookup then writeback.
module aes_subbytes_seq #(
    parameter int unsigned WORDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam int unsigned W        = WORDS_PER_CYCLE;
    localparam logic [1:0]  LAST_CNT = 2'(4 - W);
    localparam logic [1:0]  CNT_STEP = 2'(W);

    // Reject lane counts that do not divide the four-word state evenly
    generate
        if (!(W == 1 || W == 2 || W == 4)) begin : g_bad_param
            $error("aes_subbytes_seq: WORDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] blk;
    logic [127:0] blk_nxt;
    logic         wb_fire;
    logic [31:0]  blk_w     [4];
    logic [31:0]  nxt_w     [4];
    logic [31:0]  lane_word [W];
    logic [31:0]  wb_word   [W];
`ifdef SUBBYTES_PIPE_EN
    logic         ph;
    logic [31:0]  lane_q    [W];
`endif

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(a, a);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // S-box lanes on the current words and the in-place writeback image
    always_comb begin
        blk_nxt = '0;
        for (int w = 0; w < 4; w++) blk_w[w] = blk[127 - 32*w -: 32];
        nxt_w = blk_w;
        for (int unsigned l = 0; l < W; l++) begin
            lane_word[l] = sub_word(blk_w[cnt + 2'(l)]);
`ifdef SUBBYTES_PIPE_EN
            wb_word[l] = lane_q[l];
`else
            wb_word[l] = lane_word[l];
`endif
            nxt_w[cnt + 2'(l)] = wb_word[l];
        end
        for (int w = 0; w < 4; w++) blk_nxt[127 - 32*w -: 32] = nxt_w[w];
`ifdef SUBBYTES_PIPE_EN
        wb_fire = ph;
`else
        wb_fire = 1'b1;
`endif
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            blk       <= '0;
            out_block <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef SUBBYTES_PIPE_EN
            ph        <= 1'b0;
            for (int unsigned l = 0; l < W; l++) lane_q[l] <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        blk      <= in_block;
                        cnt      <= '0;
                        state    <= SUB;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUB: begin
`ifdef SUBBYTES_PIPE_EN
                    if (!ph) begin
                        for (int unsigned l = 0; l < W; l++) lane_q[l] <= lane_word[l];
                    end
                    ph <= !ph;
`endif
                    if (wb_fire) begin
                        blk <= blk_nxt;
                        cnt <= cnt + CNT_STEP;
                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_block <= blk_nxt;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
